// File: rtl/fetch_unit.sv
// fetch_unit: MIPS fetch stage (PC, imem handshake, next-PC); FETCH_PERF_CNT_EN adds fetch_count
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        stall
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
    state_t state;
    logic [31:0] next_pc;
    assign imem_req  = state == FETCH;
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    always_comb
        next_pc = jump ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                  (branch && zero) ? pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00} :
                  pc_plus4;
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: if (imem_ready) begin
                    instr       <= imem_rdata;
                    instr_valid <= 1'b1;
                    state       <= EXEC;
                end
                EXEC: if (!stall) begin
                    pc          <= next_pc;
                    instr_valid <= 1'b0;
                    state       <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            fetch_count <= '0;
        else if (state == EXEC && !stall)
            fetch_count <= fetch_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch/branch/jump/stall/reset vectors checked against a behavioural model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset, imem_req, imem_ready, instr_valid, branch, zero, jump, stall;
    logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4;
    logic [31:0] fetch_count;
    int          tests = 0, fails = 0;
    bit          active = 1'b0;
    int          m_ph;
    logic [31:0] m_pc, m_instr, m_cnt, cur_a, cur_w;

    fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .branch(branch),
        .zero(zero), .jump(jump), .stall(stall)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count)
`endif
    );

`ifndef FETCH_PERF_CNT_EN
    assign fetch_count = 32'd0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input logic j, input logic b, input logic z);
        logic [31:0] p4;
        logic signed [15:0] imm;
        int off;
        p4 = p + 32'd4;
        imm = w[15:0];
        off = imm;
        if (j) return (p4 & 32'hF000_0000) | ({6'd0, w[25:0]} * 32'd4);
        if (b && z) return p4 + 32'(off * 4);
        return p4;
    endfunction

    // m_ph: 0 = waiting one idle cycle, 1 = request outstanding, 2 = instruction held for execution
    always @(posedge clk) begin
        if (reset) begin
            m_ph = 0; m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0;
        end else if (m_ph == 0) begin
            m_ph = 1;
        end else if (m_ph == 1) begin
            if (imem_ready) begin m_instr = imem_rdata; m_ph = 2; end
        end else if (!stall) begin
            m_pc = model_next(m_pc, m_instr, jump, branch, zero);
            m_cnt = m_cnt + 32'd1;
            m_ph = 1;
        end
    end

    always @(negedge clk) if (active) begin
        chk("m_req", imem_req, 32'(m_ph == 1));
        chk("m_valid", instr_valid, 32'(m_ph == 2));
        chk("m_addr", imem_addr, m_pc);
        chk("m_pc", pc, m_pc);
        chk("m_p4", pc_plus4, m_pc + 32'd4);
        chk("m_instr", instr, m_instr);
`ifdef FETCH_PERF_CNT_EN
        chk("m_count", fetch_count, m_cnt);
`endif
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] w, input int waits);
        chk("req_f", imem_req, 1);
        chk("addr_f", imem_addr, a);
        chk("valid_f", instr_valid, 0);
        {branch, zero, jump, stall} = 4'($urandom);
        imem_ready = 1'b0;
        repeat (waits) begin
            step();
            chk("hold_req", imem_req, 1);
            chk("hold_addr", imem_addr, a);
        end
        imem_ready = 1'b1;
        imem_rdata = w;
        step();
        cur_a = a; cur_w = w;
        chk("valid_e", instr_valid, 1);
        chk("instr_e", instr, w);
        chk("pc_e", pc, a);
        chk("p4_e", pc_plus4, a + 32'd4);
        chk("req_e", imem_req, 0);
    endtask

    task automatic exec(input logic b, input logic z, input logic j, input int stalls,
                        input logic [31:0] nxt);
        branch = b; zero = z; jump = j;
        imem_ready = 1'($urandom);
        imem_rdata = $urandom;
        stall = 1'b1;
        repeat (stalls) begin
            step();
            chk("stall_valid", instr_valid, 1);
            chk("stall_req", imem_req, 0);
            chk("stall_pc", pc, cur_a);
            chk("stall_instr", instr, cur_w);
        end
        stall = 1'b0;
        step();
        chk("next_valid", instr_valid, 0);
        chk("next_req", imem_req, 1);
        chk("next_addr", imem_addr, nxt);
        {branch, zero, jump, stall} = 4'($urandom);
    endtask

    task automatic after_reset();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_p4", pc_plus4, 32'h4);
        chk("rst_count", fetch_count, 32'h0);
        reset = 1'b0;
        step();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0;
        branch = 1'b0; zero = 1'b0; jump = 1'b0; stall = 1'b0;
        step();
        active = 1'b1;
        step();
        after_reset();
        for (int i = 0; i < 4; i++) begin
            fetch(32'(i * 4), 32'h0, 0);
            exec(0, 0, 0, 0, 32'(i * 4 + 4));
        end
        fetch(32'h10, 32'h0, 3);
        exec(0, 0, 0, 0, 32'h14);
        for (int i = 5; i < 8; i++) begin
            fetch(32'(i * 4), 32'h0, 0);
            exec(0, 0, 0, 0, 32'(i * 4 + 4));
        end
        fetch(32'h20, 32'h1000_FFFE, 0);
        exec(1, 1, 0, 0, 32'h1C);
        fetch(32'h1C, 32'h0, 0);
        exec(0, 0, 0, 0, 32'h20);
        fetch(32'h20, 32'h1000_FFFE, 0);
        exec(1, 0, 0, 0, 32'h24);
        fetch(32'h24, 32'h1234_5678, 0);
        exec(0, 0, 0, 2, 32'h28);
`ifdef FETCH_PERF_CNT_EN
        chk("count_12", fetch_count, 32'd12);
`endif
        fetch(32'h28, 32'h0800_0010, 0);
        exec(1, 1, 1, 0, 32'h40);
        fetch(32'h40, 32'h0800_0010, 0);
        exec(1, 1, 1, 0, 32'h40);
        fetch(32'h40, 32'h1000_FFEE, 0);
        exec(1, 1, 0, 0, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h0, 0);
        exec(0, 0, 0, 0, 32'h0);
        fetch(32'h0, 32'h1000_FFFD, 0);
        exec(1, 1, 0, 0, 32'hFFFF_FFF8);
        fetch(32'hFFFF_FFF8, 32'h0800_0010, 0);
        exec(0, 0, 1, 0, 32'hF000_0040);
        fetch(32'hF000_0040, 32'h1000_0003, 0);
        exec(1, 1, 0, 0, 32'hF000_0050);
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        after_reset();
        fetch(32'h0, 32'hABCD_0123, 0);
        reset = 1'b1;
        step();
        after_reset();
        fetch(32'h0, 32'h0, 1);
        exec(0, 0, 0, 1, 32'h4);
        @(negedge clk);
        active = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
